// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD command engine.
//   - response-type encodings of Command[1:0]
//   - engine state enum
//   - CRC7 polynomial (x^7 + x^3 + 1)
//   - cmd_t: the Command register fields the engine actually uses
package sd_pkg;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_136  = 2'b01;
    localparam logic [1:0] RESP_48   = 2'b10;
    localparam logic [1:0] RESP_48B  = 2'b11;   // busy variant, handled as 48-bit

    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT,
        ST_RX,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [5:0] index;
        logic       idx_chk;
        logic       crc_chk;
        logic [1:0] rtype;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [15:0] c);
        cmd_t d;
        d.index   = c[13:8];
        d.idx_chk = c[4];
        d.crc_chk = c[3];
        d.rtype   = c[1:0];
        return d;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: bit-serial CRC7 (x^7 + x^3 + 1), MSB first, initial value 0.
//   clk, reset_n : clock / async active-low reset
//   clear        : synchronous clear to 0 (wins over enable)
//   enable       : fold bit_in into the CRC this cycle
//   bit_in       : serial data bit
//   crc          : current CRC value
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;
    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    crc <= '0;
        else if (clear)  crc <= '0;
        else if (enable) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: serialises one 48-bit SD command token on CMD and optionally
// captures a 48- or 136-bit response.
//   clk, reset_n        : SD clock / async active-low reset
//   start               : one-cycle request, honoured only in IDLE
//   command, argument   : Command / Argument register values, latched on start
//   cmd_out, cmd_oe     : registered CMD line drive value / output enable
//   cmd_in              : CMD line sampled value
//   busy, done          : not-IDLE flag / one-cycle completion pulse
//   timeout_err, crc_err, index_err : held until the next accepted start
//   response            : captured payload, updated only by a completed RX
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int unsigned timeout_cycles = 64
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  command,
    input  logic [31:0]  argument,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         index_err,
    output logic [127:0] response
);

    localparam int WW = $clog2(timeout_cycles + 1);

    state_t         state, state_nx;
    cmd_t           cmd_q;
    logic [7:0]     bit_cnt;
    logic [WW-1:0]  wait_cnt;
    logic [39:0]    tx_sr;      // remaining token bits 46..8, left aligned
    logic [135:0]   rx_sr;
    logic [6:0]     crc_val;
    logic [7:0]     rx_len;
    logic           crc_clr, crc_en, crc_bit;

    // Command bits the engine has no use for, and response header bits that
    // are never reported, are folded here so their non-use is explicit.
    logic unused_bits;
    assign unused_bits = ^{command[15:14], command[7:5], command[2], rx_sr[135:128]};

    assign rx_len = (cmd_q.rtype == RESP_136) ? 8'd136 : 8'd48;

    // The start bit of both token and response is 0, and folding a 0 into a
    // zero CRC leaves it zero, so clearing through the start-bit cycle is
    // equivalent to including it.
    assign crc_clr = (state == ST_IDLE) || (state == ST_WAIT && !cmd_in);
    assign crc_en  = (state == ST_TX || state == ST_RX) && bit_cnt != 8'd0 && bit_cnt < 8'd40;
    assign crc_bit = (state == ST_TX) ? tx_sr[39] : cmd_in;

    sd_crc7 u_crc (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (crc_clr),
        .enable (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_val)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        case (state)
            ST_IDLE: if (start) state_nx = ST_TX;
            ST_TX:   if (bit_cnt == 8'd48)
                         state_nx = (cmd_q.rtype == RESP_NONE) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (!cmd_in) state_nx = ST_RX;
                     else if (wait_cnt == WW'(timeout_cycles - 1)) state_nx = ST_DONE;
            ST_RX:   if (bit_cnt == rx_len) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // bit_cnt counts token bits already driven (TX) or response bits already
    // sampled (RX); the cycle after the last bit is the exit cycle of both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_out     <= 1'b1;
            cmd_oe      <= 1'b0;
            cmd_q       <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            timeout_err <= 1'b0;
            crc_err     <= 1'b0;
            index_err   <= 1'b0;
            response    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    cmd_q       <= decode_cmd(command);
                    tx_sr       <= {1'b1, command[13:8], argument, 1'b0};
                    cmd_out     <= 1'b0;        // token bit 47
                    cmd_oe      <= 1'b1;
                    bit_cnt     <= 8'd1;
                    timeout_err <= 1'b0;
                    crc_err     <= 1'b0;
                    index_err   <= 1'b0;
                end
                ST_TX: begin
                    if (bit_cnt == 8'd48) begin
                        cmd_out  <= 1'b1;
                        cmd_oe   <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt < 8'd40) begin
                            cmd_out <= tx_sr[39];
                            tx_sr   <= {tx_sr[38:0], 1'b0};
                        end else if (bit_cnt < 8'd47) begin
                            cmd_out <= crc_val[3'(8'd46 - bit_cnt)];
                        end else begin
                            cmd_out <= 1'b1;    // end bit
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cmd_in) begin
                        bit_cnt <= 8'd1;
                        rx_sr   <= '0;          // start bit already in place
                    end else if (wait_cnt == WW'(timeout_cycles - 1)) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RX: begin
                    if (bit_cnt == rx_len) begin
                        if (cmd_q.rtype == RESP_136) begin
                            response <= {8'h00, rx_sr[127:8]};
                            crc_err  <= ~rx_sr[0];
                        end else begin
                            response  <= {96'h0, rx_sr[39:8]};
                            crc_err   <= ~rx_sr[0] |
                                         (cmd_q.crc_chk & (rx_sr[7:1] != crc_val));
                            index_err <= cmd_q.idx_chk & (rx_sr[45:40] != cmd_q.index);
                        end
                    end else begin
                        rx_sr   <= {rx_sr[134:0], cmd_in};
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed + randomised checks of sd_cmd_engine against a
// token/response model built straight from the command/response formats.
module tb_sd_cmd_engine;

    localparam int T = 64;

    logic         clk = 1'b0;
    logic         reset_n, start, cmd_in;
    logic [15:0]  command;
    logic [31:0]  argument;
    logic         cmd_out, cmd_oe, busy, done, timeout_err, crc_err, index_err;
    logic [127:0] response;

    int passed = 0;
    int total  = 0;
    logic [127:0] exp_resp;

    sd_cmd_engine #(.timeout_cycles(T)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .command(command),
        .argument(argument), .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_in(cmd_in),
        .busy(busy), .done(done), .timeout_err(timeout_err), .crc_err(crc_err),
        .index_err(index_err), .response(response)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] crc7_of(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] token_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7_of(h), 1'b1};
    endfunction

    // Issue one command at "edge N" and follow it to completion.
    // k = 0 with a response type means the card never answers.
    task automatic run_cmd(input string nm, input logic [15:0] cmd, input logic [31:0] arg,
                           input int k, input logic [135:0] reply, input bit poke);
        logic [47:0] tok, r48;
        logic        oe_all, busy_all, early, e_crc, e_idx;
        int          len;
        tok = '0; oe_all = 1'b1; busy_all = 1'b1; early = 1'b0;
        command = cmd; argument = arg; start = 1'b1;
        tick();
        start = 1'b0; command = 16'($urandom); argument = $urandom;
        for (int i = 0; i < 48; i++) begin
            tok      = {tok[46:0], cmd_out};
            oe_all   = oe_all & cmd_oe;
            busy_all = busy_all & busy;
            start    = (poke && i == 10);   // must be ignored while busy
            tick();
        end
        start = 1'b0;
        chk({nm, ".token"}, 128'(tok), 128'(token_of(cmd[13:8], arg)));
        chk({nm, ".tx_oe"}, 128'(oe_all), 128'(1'b1));
        chk({nm, ".tx_busy"}, 128'(busy_all), 128'(1'b1));
        e_crc = 1'b0; e_idx = 1'b0;
        if (cmd[1:0] == 2'b00) begin
            chk({nm, ".done"}, 128'(done), 128'(1'b1));
            chk({nm, ".tmo"}, 128'(timeout_err), 128'(1'b0));
        end else if (k == 0) begin
            chk({nm, ".wait_oe"}, 128'(cmd_oe), 128'(1'b0));
            for (int j = 0; j < T; j++) begin
                early = early | done;
                tick();
            end
            chk({nm, ".early"}, 128'(early), 128'(1'b0));
            chk({nm, ".done"}, 128'(done), 128'(1'b1));
            chk({nm, ".tmo"}, 128'(timeout_err), 128'(1'b1));
        end else begin
            len = (cmd[1:0] == 2'b01) ? 136 : 48;
            for (int j = 1; j < k; j++) begin
                cmd_in = 1'b1; early = early | done;
                tick();
            end
            for (int b = len - 1; b >= 0; b--) begin
                cmd_in = reply[b]; early = early | done;
                tick();
            end
            cmd_in = 1'b1; early = early | done;
            tick();
            if (len == 136) begin
                exp_resp = {8'h00, reply[127:8]};
                e_crc    = ~reply[0];
            end else begin
                r48      = reply[47:0];
                exp_resp = {96'h0, r48[39:8]};
                e_crc    = ~r48[0] | (cmd[3] & (r48[7:1] != crc7_of(r48[47:8])));
                e_idx    = cmd[4] & (r48[45:40] != cmd[13:8]);
            end
            chk({nm, ".early"}, 128'(early), 128'(1'b0));
            chk({nm, ".done"}, 128'(done), 128'(1'b1));
            chk({nm, ".tmo"}, 128'(timeout_err), 128'(1'b0));
        end
        chk({nm, ".crc"}, 128'(crc_err), 128'(e_crc));
        chk({nm, ".idx"}, 128'(index_err), 128'(e_idx));
        chk({nm, ".resp"}, response, exp_resp);
        tick();
        chk({nm, ".idle"}, 128'({done, busy}), 128'(2'b00));
        chk({nm, ".hold"}, 128'({crc_err, index_err}), 128'({e_crc, e_idx}));
    endtask

    initial begin
        logic [39:0]  h;
        logic [135:0] rep;
        logic [15:0]  c;
        int           k;

        reset_n = 1'b0; start = 1'b0; cmd_in = 1'b1; command = '0; argument = '0;
        exp_resp = '0;
        repeat (3) tick();
        chk("rst.cmd_out", 128'(cmd_out), 128'(1'b1));
        chk("rst.oe_busy_done", 128'({cmd_oe, busy, done}), 128'(3'b000));
        chk("rst.errs", 128'({timeout_err, crc_err, index_err}), 128'(3'b000));
        chk("rst.resp", response, 128'h0);
        reset_n = 1'b1;
        tick();

        // CMD0, no response: fixed known token
        run_cmd("cmd0", 16'h0000, 32'h0, 0, '0, 1'b0);
        // CMD8 with R7 reply, both checks enabled, start bit at the first WAIT sample
        run_cmd("cmd8", 16'h081A, 32'h000001AA, 1, 136'h08000001AA13, 1'b0);
        chk("cmd8.resp_lit", response, 128'h1AA);
        // CMD17 with no reply: timeout, response held
        run_cmd("cmd17", 16'h111A, 32'h0, 0, '0, 1'b0);
        // corrupted CRC byte
        run_cmd("cmd8crc", 16'h081A, 32'h000001AA, 5, 136'h08000001AA15, 1'b0);
        chk("cmd8crc.lit", 128'(crc_err), 128'(1'b1));
        // wrong index, valid CRC, latest possible start bit
        h = 40'h09000001AA;
        run_cmd("cmd8idx", 16'h081A, 32'h000001AA, T - 1, 136'({h, crc7_of(h), 1'b1}), 1'b1);
        chk("cmd8idx.lit", 128'(index_err), 128'(1'b1));
        // CMD2, 136-bit
        rep = {8'h3F, 120'h0123456789ABCDEF0123456789ABCD, 8'h55};
        run_cmd("cmd2", 16'h0209, 32'h0, 2, rep, 1'b0);
        chk("cmd2.lit", response, 128'h000123456789ABCDEF0123456789ABCD);

        // reset in the middle of TX
        command = 16'h0000; argument = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst.oe_busy", 128'({cmd_oe, busy}), 128'(2'b00));
        chk("midrst.cmd_out", 128'(cmd_out), 128'(1'b1));
        chk("midrst.resp", response, 128'h0);
        exp_resp = '0;
        tick();
        reset_n = 1'b1;
        tick();
        run_cmd("postrst", 16'h0000, 32'h0, 0, '0, 1'b0);

        // randomised commands and replies
        for (int n = 0; n < 10; n++) begin
            c = {2'b00, 6'($urandom_range(0, 63)), 3'b000, 2'($urandom_range(0, 3)),
                 1'b0, 2'($urandom_range(0, 3))};
            if (c[1:0] == 2'b01) begin
                rep = {8'h3F, 24'($urandom), $urandom, $urandom, $urandom, 7'($urandom),
                       1'($urandom_range(0, 3) != 0)};
            end else begin
                h = {2'b00, ($urandom_range(0, 1) != 0) ? c[13:8] : 6'($urandom), $urandom};
                rep = 136'({h, ($urandom_range(0, 1) != 0) ? crc7_of(h) : 7'($urandom),
                            1'($urandom_range(0, 3) != 0)});
            end
            k = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T - 1);
            run_cmd("rnd", c, $urandom, k, rep, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
